// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - decode constants shared by the ID stage and its operand selectors
//
// Purpose: RV32 opcodes, ALU op codes, MDU op enum and the fixed decode-record
// (DCR) field map. Any DCR widening appends MSBs above DCR_BASE_W, which read 0.
//
// DCR map:
//   [0]      AUIPC
//   [3:1]    MA_TYPE (funct3 of load/store)
//   [4]      LOAD      [5] STORE     [6] BR       [7] JAL
//   [8]      JALR      [9] LUI       [10] IMM_SRC (ALU B operand is the immediate)
//   [11]     MUL       [12] MEXT
//   [15:13]  MDU_OP
//   [18:16]  ALUOP
//   [20:19]  SFTOP    {arith, shift}
package id_pkg;

  localparam logic [6:0] OPC_R     = 7'h33;
  localparam logic [6:0] OPC_I     = 7'h13;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_BR    = 7'h63;
  localparam logic [6:0] OPC_JAL   = 7'h6F;
  localparam logic [6:0] OPC_JALR  = 7'h67;
  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;

  // ALU op codes share the funct3 space, SUB borrowing the funct7[5] OR-in.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  localparam int DCR_AUIPC      = 0;
  localparam int DCR_MA_TYPE_LO = 1;
  localparam int DCR_MA_TYPE_HI = 3;
  localparam int DCR_LOAD       = 4;
  localparam int DCR_STORE      = 5;
  localparam int DCR_BR         = 6;
  localparam int DCR_JAL        = 7;
  localparam int DCR_JALR       = 8;
  localparam int DCR_LUI        = 9;
  localparam int DCR_IMM_SRC    = 10;
  localparam int DCR_MUL        = 11;
  localparam int DCR_MEXT       = 12;
  localparam int DCR_MDU_OP_LO  = 13;
  localparam int DCR_MDU_OP_HI  = 15;
  localparam int DCR_ALUOP_LO   = 16;
  localparam int DCR_ALUOP_HI   = 18;
  localparam int DCR_SFTOP_LO   = 19;
  localparam int DCR_SFTOP_HI   = 20;
  localparam int DCR_BASE_W     = 21;

  // Branch compare op: eq/ne subtract, lt/ge signed compare, ltu/geu unsigned.
  // Equivalent to {0, f3[2], ~(f3[2]^f3[1])}.
  function automatic logic [2:0] br_alu_op(input logic [2:0] f3);
    case (f3[2:1])
      2'b00:   return ALU_SUB;
      2'b10:   return ALU_SLT;
      2'b11:   return ALU_SLTU;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/id_fwd_sel.sv
// rtl/id_fwd_sel.sv - priority operand selector over the forwarding sources
//
// Purpose: resolve one register operand against NUM_FWD forwarding sources.
// Index 0 is the youngest source and wins over any older match. x0 never hits.
// Ports:
//   addr         source register address
//   fwd_valid    per-source "will write rd"
//   fwd_pending  per-source "data not ready yet"
//   fwd_waddr    packed destination addresses, 5 bits per source
//   fwd_wdata    packed write data, 32 bits per source
//   rf_rdata     register-file data used when nothing matches
//   data         resolved operand
//   hit          some source matched
//   pending      the winning source has no data yet
module id_fwd_sel #(
  parameter int NUM_FWD = 3
) (
  input  logic [4:0]            addr,
  input  logic [NUM_FWD-1:0]    fwd_valid,
  input  logic [NUM_FWD-1:0]    fwd_pending,
  input  logic [5*NUM_FWD-1:0]  fwd_waddr,
  input  logic [32*NUM_FWD-1:0] fwd_wdata,
  input  logic [31:0]           rf_rdata,
  output logic [31:0]           data,
  output logic                  hit,
  output logic                  pending
);

  always_comb begin
    data    = rf_rdata;
    hit     = 1'b0;
    pending = 1'b0;
    if (addr != 5'd0) begin
      // First match in ascending index order is the youngest writer.
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit && fwd_valid[i] && (fwd_waddr[5*i +: 5] == addr)) begin
          hit     = 1'b1;
          pending = fwd_pending[i];
          data    = fwd_wdata[32*i +: 32];
        end
      end
    end
  end

endmodule

// File: rtl/stage_id_fwd.sv
// rtl/stage_id_fwd.sv - RV32 decode stage with generic forwarding and valid/ready handshake
//
// Purpose: decode one instruction per cycle into immediate, decode record and
// jump/branch target, resolve both operands against NUM_FWD forwarding sources,
// and interlock on a load-use hazard. One-cycle latency into a single output
// register; flush from EX kills the register contents and the offered input.
// Optional build macro: STAGE_ID_MEXT_EN enables full RV32M decode (MEXT + MDU_OP);
// without it only MUL is recognised and other funct7==1 R-type encodings are illegal.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        IF handshake; in_inst, in_pc payload
//   flush                    redirect from EX
//   rf_raddr1/2, rf_rdata1/2 register-file read port (same-cycle data)
//   fwd_valid/pending/waddr/wdata  forwarding sources, index 0 youngest
//   out_valid/out_ready      EX handshake
//   out_pc, out_rr1, out_rr2, out_imm, out_target, out_rd, out_dcr, out_ill  decoded payload
module stage_id_fwd #(
  parameter int          NUM_FWD  = 3,
  parameter int          DCR_W    = 24,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [31:0]           in_pc,
  input  logic                  flush,
  output logic [4:0]            rf_raddr1,
  output logic [4:0]            rf_raddr2,
  input  logic [31:0]           rf_rdata1,
  input  logic [31:0]           rf_rdata2,
  input  logic [NUM_FWD-1:0]    fwd_valid,
  input  logic [NUM_FWD-1:0]    fwd_pending,
  input  logic [5*NUM_FWD-1:0]  fwd_waddr,
  input  logic [32*NUM_FWD-1:0] fwd_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_rr1,
  output logic [31:0]           out_rr2,
  output logic [31:0]           out_imm,
  output logic [31:0]           out_target,
  output logic [4:0]            out_rd,
  output logic [DCR_W-1:0]      out_dcr,
  output logic                  out_ill
);

  import id_pkg::*;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;

  logic        is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic        ill, mul, mext;
  logic [2:0]  mdu_op;
  logic [2:0]  alu_op;
  logic [1:0]  sft_op;
  logic [31:0] imm;
  logic        use_rs1, use_rs2, writes_rd;

  logic [31:0] rr1, rr2;
  logic        hit1, hit2, pend1, pend2;
  logic        stall, fire_in;

  logic [31:0]      tgt_base, tgt_sum, target;
  logic [4:0]       rd;
  logic [DCR_W-1:0] dcr;

  assign opc       = in_inst[6:0];
  assign f3        = in_inst[14:12];
  assign f7        = in_inst[31:25];
  assign rf_raddr1 = in_inst[19:15];
  assign rf_raddr2 = in_inst[24:20];

  id_fwd_sel #(.NUM_FWD(NUM_FWD)) u_sel1 (
    .addr        (rf_raddr1),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_waddr   (fwd_waddr),
    .fwd_wdata   (fwd_wdata),
    .rf_rdata    (rf_rdata1),
    .data        (rr1),
    .hit         (hit1),
    .pending     (pend1)
  );

  id_fwd_sel #(.NUM_FWD(NUM_FWD)) u_sel2 (
    .addr        (rf_raddr2),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_waddr   (fwd_waddr),
    .fwd_wdata   (fwd_wdata),
    .rf_rdata    (rf_rdata2),
    .data        (rr2),
    .hit         (hit2),
    .pending     (pend2)
  );

  // Opcode class, immediate, ALU/shift/MDU ops and legality.
  always_comb begin
    is_r     = 1'b0;
    is_i     = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_br    = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    is_lui   = 1'b0;
    is_auipc = 1'b0;
    ill      = 1'b0;
    mul      = 1'b0;
    mext     = 1'b0;
    mdu_op   = 3'd0;
    alu_op   = ALU_ADD;
    sft_op   = 2'b00;
    imm      = 32'd0;
    case (opc)
      OPC_R: begin
        is_r   = 1'b1;
        alu_op = f3 | {2'b00, f7[5]};
        if (f7 == 7'h01) begin
`ifdef STAGE_ID_MEXT_EN
          mext   = 1'b1;
          mdu_op = f3;
          mul    = (mdu_op_e'(f3) == MDU_MUL);
`else
          if (mdu_op_e'(f3) == MDU_MUL) mul = 1'b1;
          else                          ill = 1'b1;
`endif
        end else if (f3[1:0] == 2'b01) begin
          sft_op = {in_inst[30], 1'b1};
        end
      end
      OPC_I: begin
        is_i   = 1'b1;
        alu_op = f3;
        imm    = {{20{in_inst[31]}}, in_inst[31:20]};
        if (f3[1:0] == 2'b01) sft_op = {in_inst[30], 1'b1};
      end
      OPC_LOAD: begin
        is_load = 1'b1;
        imm     = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_STORE: begin
        is_store = 1'b1;
        imm      = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OPC_BR: begin
        is_br  = 1'b1;
        alu_op = br_alu_op(f3);
        imm    = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                  in_inst[11:8], 1'b0};
      end
      OPC_JAL: begin
        is_jal = 1'b1;
        imm    = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                  in_inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        is_jalr = 1'b1;
        imm     = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_LUI: begin
        is_lui = 1'b1;
        imm    = {in_inst[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        is_auipc = 1'b1;
        imm      = {in_inst[31:12], 12'd0};
      end
      default: ill = 1'b1;
    endcase
  end

  assign use_rs1   = is_r | is_i | is_load | is_store | is_br | is_jalr;
  assign use_rs2   = is_r | is_store | is_br;
  assign writes_rd = is_r | is_i | is_load | is_jalr | is_lui | is_auipc | is_jal;
  assign rd        = (writes_rd && !ill) ? in_inst[11:7] : 5'd0;

  // Only a used operand whose youngest matching source lacks data interlocks.
  assign stall    = in_valid & ((use_rs1 & hit1 & pend1) | (use_rs2 & hit2 & pend2));
  assign in_ready = ~stall & ~flush & (~out_valid | out_ready);
  assign fire_in  = in_valid & in_ready;

  // JALR targets off the forwarded rs1; low two bits are dropped for all jumps.
  assign tgt_base = is_jalr ? rr1 : in_pc;
  assign tgt_sum  = tgt_base + imm;
  assign target   = (is_br | is_jal | is_jalr) ? {tgt_sum[31:2], 2'b00} : (in_pc + 32'd4);

  always_comb begin
    dcr = '0;
    dcr[DCR_AUIPC]                     = is_auipc;
    dcr[DCR_MA_TYPE_HI:DCR_MA_TYPE_LO] = (is_load | is_store) ? f3 : 3'd0;
    dcr[DCR_LOAD]                      = is_load;
    dcr[DCR_STORE]                     = is_store;
    dcr[DCR_BR]                        = is_br;
    dcr[DCR_JAL]                       = is_jal;
    dcr[DCR_JALR]                      = is_jalr;
    dcr[DCR_LUI]                       = is_lui;
    dcr[DCR_IMM_SRC]                   = is_i | is_load | is_store | is_jalr | is_lui | is_auipc;
    dcr[DCR_MUL]                       = mul;
    dcr[DCR_MEXT]                      = mext;
    dcr[DCR_MDU_OP_HI:DCR_MDU_OP_LO]   = mdu_op;
    dcr[DCR_ALUOP_HI:DCR_ALUOP_LO]     = alu_op;
    dcr[DCR_SFTOP_HI:DCR_SFTOP_LO]     = sft_op;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_pc     <= PC_RESET;
      out_rr1    <= 32'd0;
      out_rr2    <= 32'd0;
      out_imm    <= 32'd0;
      out_target <= PC_RESET;
      out_rd     <= 5'd0;
      out_dcr    <= '0;
      out_ill    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire_in) begin
      out_valid  <= 1'b1;
      out_pc     <= in_pc;
      out_rr1    <= rr1;
      out_rr2    <= rr2;
      out_imm    <= imm;
      out_target <= target;
      out_rd     <= rd;
      out_dcr    <= dcr;
      out_ill    <= ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_id_fwd.sv
// tb/tb_stage_id_fwd.sv - self-checking bench for stage_id_fwd
module tb_stage_id_fwd;
  import id_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_inst = 32'd0;
  logic [31:0]  in_pc = 32'd0;
  logic         flush = 1'b0;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [31:0]  rf_rdata1 = 32'd0;
  logic [31:0]  rf_rdata2 = 32'd0;
  logic [2:0]   fwd_valid = 3'd0;
  logic [2:0]   fwd_pending = 3'd0;
  logic [14:0]  fwd_waddr = 15'd0;
  logic [95:0]  fwd_wdata = 96'd0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_pc, out_rr1, out_rr2, out_imm, out_target;
  logic [4:0]   out_rd;
  logic [23:0]  out_dcr;
  logic         out_ill;

  stage_id_fwd dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rr1(out_rr1), .out_rr2(out_rr2), .out_imm(out_imm),
    .out_target(out_target), .out_rd(out_rd), .out_dcr(out_dcr), .out_ill(out_ill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst, pc, rf1, rf2, rr1, rr2, imm, target;
    logic [4:0]  rd;
    logic [23:0] dcr;
    logic        ill;
  } vec_t;

  vec_t tbl[$];
  vec_t q[$];
  vec_t cur;
  vec_t dropped;
  int   n_tests = 0;
  int   n_fail = 0;
  logic last_fire = 1'b0;

`ifdef STAGE_ID_MEXT_EN
  localparam logic [23:0] MUL_DCR = 24'h001800;
  localparam logic [23:0] DIV_DCR = 24'h049000;
  localparam logic [4:0]  DIV_RD  = 5'd5;
  localparam logic        DIV_ILL = 1'b0;
`else
  localparam logic [23:0] MUL_DCR = 24'h000800;
  localparam logic [23:0] DIV_DCR = 24'h040000;
  localparam logic [4:0]  DIV_RD  = 5'd0;
  localparam logic        DIV_ILL = 1'b1;
`endif

  function automatic vec_t mk(input logic [31:0] inst, pc, rf1, rf2, rr1, rr2, imm, target,
                              input logic [4:0] rd, input logic [23:0] dcr, input logic ill);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rf1 = rf1; v.rf2 = rf2; v.rr1 = rr1; v.rr2 = rr2;
    v.imm = imm; v.target = target; v.rd = rd; v.dcr = dcr; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cur       = v;
    in_inst   = v.inst;
    in_pc     = v.pc;
    rf_rdata1 = v.rf1;
    rf_rdata2 = v.rf2;
    in_valid  = 1'b1;
  endtask

  // One clock: scoreboard push on input handshake, pop/compare on output handshake.
  task automatic tick();
    vec_t e;
    @(negedge clk);
    last_fire = in_valid && in_ready;
    if (last_fire) q.push_back(cur);
    if (out_valid && out_ready && !flush) begin
      if (q.size() == 0) begin
        chk("unexpected_output_queue_size", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk($sformatf("pc@%h", e.pc), out_pc, e.pc);
        chk($sformatf("rr1@%h", e.pc), out_rr1, e.rr1);
        chk($sformatf("rr2@%h", e.pc), out_rr2, e.rr2);
        chk($sformatf("imm@%h", e.pc), out_imm, e.imm);
        chk($sformatf("target@%h", e.pc), out_target, e.target);
        chk($sformatf("rd@%h", e.pc), {27'd0, out_rd}, {27'd0, e.rd});
        chk($sformatf("dcr@%h", e.pc), {8'd0, out_dcr}, {8'd0, e.dcr});
        chk($sformatf("ill@%h", e.pc), {31'd0, out_ill}, {31'd0, e.ill});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input vec_t v);
    drive(v);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (last_fire) break;
    end
    chk("offer_accepted", {31'd0, last_fire}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    tbl.push_back(mk(32'h00500093, 32'h100, 32'h0,    32'h99, 32'h0,    32'h99, 32'h5,        32'h104, 5'd1, 24'h000400, 1'b0));
    tbl.push_back(mk(32'h00728333, 32'h104, 32'h11,   32'h22, 32'h11,   32'h22, 32'h0,        32'h108, 5'd6, 24'h000000, 1'b0));
    tbl.push_back(mk(32'h402081B3, 32'h108, 32'h5,    32'h3,  32'h5,    32'h3,  32'h0,        32'h10C, 5'd3, 24'h010000, 1'b0));
    tbl.push_back(mk(32'hFE20AC23, 32'h10C, 32'h1000, 32'h55, 32'h1000, 32'h55, 32'hFFFFFFF8, 32'h110, 5'd0, 24'h000424, 1'b0));
    tbl.push_back(mk(32'hFE208EE3, 32'h200, 32'h1,    32'h1,  32'h1,    32'h1,  32'hFFFFFFFC, 32'h1FC, 5'd0, 24'h010040, 1'b0));
    tbl.push_back(mk(32'h123452B7, 32'h204, 32'h7,    32'h8,  32'h7,    32'h8,  32'h12345000, 32'h208, 5'd5, 24'h000600, 1'b0));
    tbl.push_back(mk(32'h010000EF, 32'h300, 32'h0,    32'h0,  32'h0,    32'h0,  32'h10,       32'h310, 5'd1, 24'h000080, 1'b0));
    tbl.push_back(mk(32'h008100E7, 32'h304, 32'h1003, 32'h4,  32'h1003, 32'h4,  32'h8,        32'h1008, 5'd1, 24'h000500, 1'b0));
    tbl.push_back(mk(32'h000001FF, 32'h308, 32'h0,    32'h0,  32'h0,    32'h0,  32'h0,        32'h30C, 5'd0, 24'h000000, 1'b1));
    tbl.push_back(mk(32'h4030D393, 32'h30C, 32'h80,   32'h6,  32'h80,   32'h6,  32'h403,      32'h310, 5'd7, 24'h1D0400, 1'b0));
    tbl.push_back(mk(32'h00C0A403, 32'h310, 32'h2000, 32'h0,  32'h2000, 32'h0,  32'hC,        32'h314, 5'd8, 24'h000414, 1'b0));
    tbl.push_back(mk(32'h00001117, 32'h314, 32'h0,    32'h0,  32'h0,    32'h0,  32'h1000,     32'h318, 5'd2, 24'h000401, 1'b0));
    tbl.push_back(mk(32'h02208233, 32'h318, 32'h6,    32'h7,  32'h6,    32'h7,  32'h0,        32'h31C, 5'd4, MUL_DCR,    1'b0));
    tbl.push_back(mk(32'h0220C2B3, 32'h31C, 32'h14,   32'h5,  32'h14,   32'h5,  32'h0,        32'h320, DIV_RD, DIV_DCR,  DIV_ILL));

    // Reset state while rst is held low.
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_pc", out_pc, 32'h0);
    chk("reset_out_target", out_target, 32'h0);
    chk("reset_out_dcr", {8'd0, out_dcr}, 32'd0);
    chk("reset_out_rd", {27'd0, out_rd}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Decode table, back to back.
    foreach (tbl[i]) offer(tbl[i]);
    drain();

    // Forward priority: youngest match wins; x0 is never forwarded.
    fwd_valid = 3'b111;
    fwd_waddr = {5'd3, 5'd0, 5'd3};
    fwd_wdata = {32'hBBBB, 32'hCCCC, 32'hAAAA};
    offer(mk(32'h000182B3, 32'h400, 32'h1234, 32'h0, 32'hAAAA, 32'h0, 32'h0, 32'h404, 5'd5, 24'h0, 1'b0));
    fwd_valid = 3'b100;
    offer(mk(32'h000182B3, 32'h404, 32'h1234, 32'h0, 32'hBBBB, 32'h0, 32'h0, 32'h408, 5'd5, 24'h0, 1'b0));
    fwd_valid = 3'b010;
    fwd_waddr = {5'd0, 5'd2, 5'd0};
    fwd_wdata = {32'h0, 32'h2000, 32'h0};
    offer(mk(32'h008100E7, 32'h500, 32'h9999, 32'h4, 32'h2000, 32'h4, 32'h8, 32'h2008, 5'd1, 24'h000500, 1'b0));
    fwd_valid = 3'b000;
    drain();

    // Load-use: unused rs1 field does not stall; used rs1 stalls until data arrives.
    fwd_valid   = 3'b001;
    fwd_pending = 3'b001;
    fwd_waddr   = {5'd0, 5'd0, 5'd5};
    fwd_wdata   = {32'h0, 32'h0, 32'h5555};
    drive(mk(32'h000280B7, 32'h600, 32'h0, 32'h0, 32'h5555, 32'h0, 32'h28000, 32'h604, 5'd1, 24'h000600, 1'b0));
    tick();
    chk("unused_operand_no_stall", {31'd0, last_fire}, 32'd1);
    drive(mk(32'h00728333, 32'h604, 32'h1, 32'h77, 32'h7777, 32'h77, 32'h0, 32'h608, 5'd6, 24'h0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("loaduse_stall_ready", {31'd0, last_fire}, 32'd0);
    end
    chk("loaduse_bubble_out_valid", {31'd0, out_valid}, 32'd0);
    fwd_pending = 3'b000;
    fwd_wdata   = {32'h0, 32'h0, 32'h7777};
    tick();
    chk("loaduse_accept", {31'd0, last_fire}, 32'd1);
    in_valid  = 1'b0;
    fwd_valid = 3'b000;
    drain();

    // Backpressure: payload held, input blocked, nothing lost or duplicated.
    out_ready = 1'b0;
    offer(mk(32'h00500093, 32'h700, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 32'h704, 5'd1, 24'h000400, 1'b0));
    drive(mk(32'h00500093, 32'h704, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 32'h708, 5'd1, 24'h000400, 1'b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_in_blocked", {31'd0, last_fire}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_pc_held", out_pc, 32'h700);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_second_accepted", {31'd0, last_fire}, 32'd1);
    in_valid = 1'b0;
    drain();

    // Flush kills the held instruction and refuses the offered one.
    out_ready = 1'b0;
    offer(mk(32'h00728333, 32'h800, 32'h1, 32'h2, 32'h1, 32'h2, 32'h0, 32'h804, 5'd6, 24'h0, 1'b0));
    drive(mk(32'h00728333, 32'h804, 32'h3, 32'h4, 32'h3, 32'h4, 32'h0, 32'h808, 5'd6, 24'h0, 1'b0));
    flush = 1'b1;
    tick();
    chk("flush_no_accept", {31'd0, last_fire}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_killed_in_queue", q.size(), 1);
    if (q.size() != 0) dropped = q.pop_front();
    flush = 1'b0;
    out_ready = 1'b1;
    offer(cur);
    drain();

    // Asynchronous reset mid-cycle clears the output register at once.
    out_ready = 1'b0;
    offer(mk(32'h010000EF, 32'h900, 32'h0, 32'h0, 32'h0, 32'h0, 32'h10, 32'h910, 5'd1, 24'h000080, 1'b0));
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_out_pc", out_pc, 32'h0);
    chk("async_rst_out_target", out_target, 32'h0);
    chk("async_rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("async_rst_out_imm", out_imm, 32'h0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
    offer(mk(32'h00500093, 32'hA00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 32'hA04, 5'd1, 24'h000400, 1'b0));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
